sap_cpu_param: RTL and testbench

Parametrised next-generation SAP core: accumulator CPU with on-chip program/data RAM, a one-hot T-state ring sequencer and a handshaked output port. Adds store, immediate load, unconditional and conditional jumps, halt, Z/C flags and a program-load port. All state is updated on the rising edge of a single clock. Sits as the CPU node under the board top, driving display/LED logic through the output port.

---
 rtl/sap_pkg.sv | 31 +++
 rtl/sap_ram.sv | 28 ++
 rtl/sap_cpu_param.sv | 186 ++++++++++++++++++
 tb/tb_sap_cpu_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP accumulator core.
//   - 4-bit opcode values (OP_LDA .. OP_HLT); any other value executes as NOP
//   - top-level FSM state enum (IDLE / RUN / HALT)
//   - bit positions T0..T5 in the one-hot T-state ring
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } cpu_state_t;

  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;
  localparam int unsigned T2 = 2;
  localparam int unsigned T3 = 3;
  localparam int unsigned T4 = 4;
  localparam int unsigned T5 = 5;

endpackage

// File: rtl/sap_ram.sv
// sap_ram: 2**ADDR_W x DATA_W program/data memory.
//   clk          write clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata  combinational read port
// Contents are never reset.
module sap_ram
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised SAP accumulator CPU.
//   clk, clr                 clock, async active-high reset
//   start                    begin execution at PC=0 (from IDLE or HALT)
//   prog_we/addr/data        RAM load port, honoured only outside RUN
//   out_data/valid/ready     output port, valid held until accepted
//   halted, busy             HALT / RUN state indicators
//   t_state                  one-hot T0..T5 ring, zero when not running
//   pc_dbg, acc_dbg, flags_dbg  PC, ACC and {C,Z}
// Every instruction runs T0..T5; OUT may stall in T3, HLT leaves after T2.
module sap_cpu_param
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              busy,
  output logic [5:0]        t_state,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg,
  output logic [1:0]        flags_dbg
);

  cpu_state_t        state_q, state_d;
  logic [5:0]        ring;
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, acc, b;
  logic              z, c;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              is_run;
  logic              out_stall;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];
  assign sum     = {1'b0, acc} + {1'b0, b};
  assign diff    = acc - b;
  assign is_run  = (state_q == RUN);
  assign out_stall = ring[T3] && (opcode == OP_OUT) && out_valid_q && !out_ready;

  sap_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar),
    .rdata(ram_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HALT: if (start) state_d = RUN;
      RUN:        if (ring[T2] && (opcode == OP_HLT)) state_d = HALT;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs and RAM port mux: the load port owns the RAM outside RUN,
  // STA's T3 owns it inside RUN.
  always_comb begin
    busy      = is_run;
    halted    = (state_q == HALT);
    t_state   = is_run ? ring : '0;
    ram_we    = is_run ? (ring[T3] && (opcode == OP_STA)) : prog_we;
    ram_waddr = is_run ? mar : prog_addr;
    ram_wdata = is_run ? acc : prog_data;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pc_dbg    = pc;
  assign acc_dbg   = acc;
  assign flags_dbg = {c, z};

  // Datapath and T-state ring. Later assignments in this block override
  // earlier ones (OUT setting valid over the handshake clear, HLT zeroing
  // the ring over the rotate).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ring        <= '0;
      pc          <= '0;
      mar         <= '0;
      ir          <= '0;
      acc         <= '0;
      b           <= '0;
      z           <= 1'b0;
      c           <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (!is_run) begin
        if (start) begin
          pc   <= '0;
          ring <= 6'b000001;
        end
      end else begin
        if (!out_stall) ring <= {ring[4:0], ring[5]};

        if (ring[T0]) mar <= pc;

        if (ring[T1]) begin
          ir <= ram_rdata;
          pc <= pc + ADDR_W'(1);
        end

        if (ring[T2]) begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
            OP_JMP: pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_LDI: begin
              acc <= DATA_W'(operand);
              z   <= (operand == '0);
            end
            OP_OUT: begin
              out_data_q  <= acc;
              out_valid_q <= 1'b1;
            end
            OP_HLT: ring <= '0;
            default: ;
          endcase
        end

        if (ring[T3]) begin
          unique case (opcode)
            OP_LDA: begin
              acc <= ram_rdata;
              z   <= (ram_rdata == '0);
            end
            OP_ADD, OP_SUB: b <= ram_rdata;
            default: ;
          endcase
        end

        if (ring[T4]) begin
          unique case (opcode)
            OP_ADD: begin
              acc <= sum[DATA_W-1:0];
              c   <= sum[DATA_W];
              z   <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              acc <= diff;
              c   <= (acc < b);
              z   <= (diff == '0);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sap_cpu_param.sv
module tb_sap_cpu_param;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       halted, busy;
  logic [5:0] t_state;
  logic [3:0] pc_dbg;
  logic [7:0] acc_dbg;
  logic [1:0] flags_dbg;

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .busy(busy), .t_state(t_state),
    .pc_dbg(pc_dbg), .acc_dbg(acc_dbg), .flags_dbg(flags_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction-level reference machine
  logic [7:0] img  [16];
  logic [7:0] mram [16];
  logic [7:0] m_acc;
  logic [3:0] m_pc;
  bit         m_z, m_c;
  logic [7:0] mq [$];
  logic [7:0] dq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_run(output int ninstr, output bit ok);
    logic [7:0] w, m;
    logic [3:0] a;
    logic [8:0] s;
    ninstr = 0;
    ok = 1'b0;
    m_pc = '0;
    for (int k = 0; k < 100; k++) begin
      w = mram[m_pc];
      m_pc = m_pc + 4'd1;
      a = w[3:0];
      m = mram[a];
      case (w[7:4])
        4'h0: begin m_acc = m; m_z = (m_acc == 8'h00); end
        4'h1: begin s = m_acc + m; m_acc = s[7:0]; m_c = s[8]; m_z = (m_acc == 8'h00); end
        4'h2: begin m_c = (m_acc < m); m_acc = m_acc - m; m_z = (m_acc == 8'h00); end
        4'h3: mram[a] = m_acc;
        4'h4: m_pc = a;
        4'h5: if (m_z) m_pc = a;
        4'h6: if (m_c) m_pc = a;
        4'h7: begin m_acc = {4'h0, a}; m_z = (a == 4'h0); end
        4'hE: mq.push_back(m_acc);
        4'hF: begin ok = 1'b1; return; end
        default: ;
      endcase
      ninstr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_acc = '0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // Loads img (address 0 last, in the same cycle as start) and starts.
  task automatic load_start();
    for (int i = 15; i >= 1; i--) begin
      @(negedge clk); prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
    end
    @(negedge clk); prog_addr = 4'd0; prog_data = img[0]; start = 1'b1;
    @(negedge clk); prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic run_case(input string name, input bit rst, input bit rnd,
                          input bit inject, input bit cyc_chk);
    int ni, n, vcyc;
    bit ok;
    if (rst) do_reset();
    mram = img;
    mq.delete();
    model_run(ni, ok);
    load_start();
    dq.delete();
    n = 0; vcyc = 0;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (halted) break;
      if (out_valid) vcyc++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && n == 7) begin
        prog_we = 1'b1; prog_addr = 4'd14; prog_data = 8'h55; start = 1'b1;
      end else begin
        prog_we = 1'b0; start = 1'b0;
      end
      if (out_valid && out_ready) dq.push_back(out_data);
    end
    prog_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk({name, " halted"}, halted, 1);
    chk({name, " busy"}, busy, 0);
    chk({name, " t_state"}, t_state, 0);
    chk({name, " pc"}, pc_dbg, m_pc);
    chk({name, " acc"}, acc_dbg, m_acc);
    chk({name, " flags"}, flags_dbg, {m_c, m_z});
    chk({name, " out count"}, dq.size(), mq.size());
    for (int i = 0; i < mq.size() && i < dq.size(); i++)
      chk($sformatf("%s out[%0d]", name, i), dq[i], mq[i]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s ram[%0d]", name, i), dut.u_ram.mem[i], mram[i]);
    if (cyc_chk) begin
      // HLT is the only instruction that stops after T2
      chk({name, " cycles"}, n, 6 * ni + 3);
      chk({name, " valid cycles"}, vcyc, mq.size());
    end
  endtask

  task automatic set_arith();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h1B; img[3] = 8'h2C;
    img[4] = 8'hE0; img[5] = 8'hF0;
    img[9] = 8'h10; img[10] = 8'h14; img[11] = 8'h18; img[12] = 8'h20;
  endtask

  initial begin
    int n, tries, ni;
    bit ok;
    logic [7:0] sa;
    logic [3:0] op;
    bit sz, sc;

    // Reset values
    @(negedge clk); clr = 1'b1;
    #1;
    chk("rst t_state", t_state, 0);
    chk("rst pc", pc_dbg, 0);
    chk("rst acc", acc_dbg, 0);
    chk("rst flags", flags_dbg, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst halted", halted, 0);
    @(negedge clk); clr = 1'b0;

    // Arithmetic program, ready always high
    set_arith();
    run_case("arith", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("arith out 1C", (dq.size() > 0) ? dq[0] : 8'hxx, 8'h1C);
    chk("arith pc 6", pc_dbg, 6);
    chk("arith flags 00", flags_dbg, 2'b00);

    // Backpressure on the same program
    do_reset();
    out_ready = 1'b0;
    load_start();
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp valid rise", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp hold t_state", t_state, 6'b001000);
      chk("bp hold data", out_data, 8'h1C);
      chk("bp hold valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp valid drop", out_valid, 0);
    chk("bp advance T4", t_state, 6'b010000);
    n = 0;
    while (!halted && n < 200) begin @(negedge clk); n++; end
    chk("bp halted", halted, 1);

    // Store and loop, with prog_we and start poked during RUN
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h73; img[1] = 8'h2F; img[2] = 8'h3E; img[3] = 8'h55;
    img[4] = 8'h41; img[5] = 8'hF0; img[14] = 8'h77; img[15] = 8'h01;
    run_case("loop", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("loop ram14", dut.u_ram.mem[14], 8'h00);
    chk("loop flags", flags_dbg, 2'b01);

    // Carry on ADD, JC taken, borrow on SUB
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h08; img[1] = 8'h19; img[2] = 8'h64; img[3] = 8'hF0;
    img[4] = 8'hE0; img[5] = 8'h0A; img[6] = 8'h2B; img[7] = 8'hF0;
    img[8] = 8'hF0; img[9] = 8'h20; img[10] = 8'h05; img[11] = 8'h07;
    run_case("carry", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("carry out 10", (dq.size() > 0) ? dq[0] : 8'hxx, 8'h10);
    chk("borrow acc FE", acc_dbg, 8'hFE);
    chk("borrow flags", flags_dbg, 2'b10);

    // PC wrap through NOP at address 15
    for (int i = 0; i < 16; i++) img[i] = 8'h80;
    img[0] = 8'h0E; img[1] = 8'h1D; img[2] = 8'h3E; img[3] = 8'h2C;
    img[4] = 8'h56; img[5] = 8'h47; img[6] = 8'hF0;
    img[12] = 8'h02; img[13] = 8'h01; img[14] = 8'h00;
    run_case("wrap", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("wrap ram14", dut.u_ram.mem[14], 8'h02);
    chk("wrap pc", pc_dbg, 7);

    // Random programs, restarted from HALT, random backpressure
    for (int r = 0; r < 8; r++) begin
      tries = 0;
      do begin
        for (int i = 0; i < 16; i++) begin
          case ($urandom_range(0, 10))
            0: op = 4'h0;  1: op = 4'h1;  2: op = 4'h2;  3: op = 4'h3;
            4: op = 4'h4;  5: op = 4'h5;  6: op = 4'h6;  7: op = 4'h7;
            8: op = 4'h9;  9: op = 4'hE;  default: op = 4'hF;
          endcase
          img[i] = {op, 4'($urandom_range(0, 15))};
        end
        sa = m_acc; sz = m_z; sc = m_c;
        mram = img;
        mq.delete();
        model_run(ni, ok);
        m_acc = sa; m_z = sz; m_c = sc;
        tries++;
      end while (!ok && tries < 50);
      if (!ok) img[0] = 8'hF0;
      run_case($sformatf("rand%0d", r), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // clr at T3 of the first ADD
    set_arith();
    do_reset();
    load_start();
    n = 0;
    while (!(pc_dbg == 4'd2 && t_state == 6'b001000) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("clr reached ADD T3", t_state, 6'b001000);
    chk("clr pre acc", acc_dbg, 8'h10);
    #1 clr = 1'b1;
    #1;
    chk("clr t_state", t_state, 0);
    chk("clr busy", busy, 0);
    chk("clr halted", halted, 0);
    chk("clr pc", pc_dbg, 0);
    chk("clr acc", acc_dbg, 0);
    chk("clr flags", flags_dbg, 0);
    chk("clr out_valid", out_valid, 0);
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("clr ram[%0d]", i), dut.u_ram.mem[i], img[i]);
    @(negedge clk);
    chk("clr idle stays", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
